// File: rtl/counter_multi_if.sv
// counter_multi_if: control and status bundle for the counter_multi bank.
// Carries the prescale field only when COUNTER_PRESCALE_EN is defined.
interface counter_multi_if #(
  parameter int WIDTH    = 32,
`ifdef COUNTER_PRESCALE_EN
  parameter int PRESCALE_W = 8,
`endif
  parameter int CHANNELS = 4
);

  logic                      clr;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       dir;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] load_val;
`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0]     prescale;
`endif
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       ping;
  logic [CHANNELS-1:0]       wrap;

  modport master (
`ifdef COUNTER_PRESCALE_EN
    output prescale,
`endif
    output clr,
    output en,
    output dir,
    output load,
    output load_val,
    input  count,
    input  ping,
    input  wrap
  );

  modport slave (
`ifdef COUNTER_PRESCALE_EN
    input  prescale,
`endif
    input  clr,
    input  en,
    input  dir,
    input  load,
    input  load_val,
    output count,
    output ping,
    output wrap
  );

endinterface

// File: rtl/counter_multi.sv
// counter_multi: CHANNELS up/down counters with load, wrap/saturate, ping and wrap pulse.
// Define COUNTER_PRESCALE_EN to add the shared tick prescaler.
module counter_multi #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int SATURATE   = 0,
  parameter int PRESCALE_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  counter_multi_if.slave bus
);

  localparam bit SAT = (SATURATE != 0);

  if (WIDTH < 2 || CHANNELS < 1 || PRESCALE_W < 1) begin : g_bad_cfg
    $error("counter_multi: illegal parameter set");
  end

  logic tick;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_cnt;

  // >= rather than == so a lowered prescale never locks out ticks
  assign tick = (pre_cnt >= bus.prescale);

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] stepped;
    logic             wrp;
    logic             at_bnd;

    assign at_bnd  = bus.dir[c] ? (&cnt) : (~|cnt);
    assign stepped = bus.dir[c] ? (cnt + 1'b1) : (cnt - 1'b1);

    always_ff @(posedge clk) begin
      if (!rst_n || bus.clr) begin
        cnt <= '0;
        wrp <= 1'b0;
      end else if (bus.load[c]) begin
        cnt <= bus.load_val[c*WIDTH +: WIDTH];
        wrp <= 1'b0;
      end else if (bus.en[c] && tick) begin
        wrp <= at_bnd;
        // saturating mode holds at the boundary but still pulses wrap
        if (!(SAT && at_bnd)) begin
          cnt <= stepped;
        end
      end else begin
        wrp <= 1'b0;
      end
    end

    assign bus.count[c*WIDTH +: WIDTH] = cnt;
    assign bus.ping[c]                 = &cnt;
    assign bus.wrap[c]                 = wrp;
  end

endmodule

// File: tb/tb_counter_multi.sv
// tb_counter_multi: directed tests on a wrapping and a saturating 4-bit, 4-channel bank.
// Prescaler scenario is compiled in when COUNTER_PRESCALE_EN is defined.
module tb_counter_multi;

  localparam int W = 4;
  localparam int C = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COUNTER_PRESCALE_EN
  counter_multi_if #(.WIDTH(W), .PRESCALE_W(8), .CHANNELS(C)) bw ();
  counter_multi_if #(.WIDTH(W), .PRESCALE_W(8), .CHANNELS(C)) bs ();
`else
  counter_multi_if #(.WIDTH(W), .CHANNELS(C)) bw ();
  counter_multi_if #(.WIDTH(W), .CHANNELS(C)) bs ();
`endif

  counter_multi #(
    .WIDTH(W), .CHANNELS(C), .SATURATE(0), .PRESCALE_W(8)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bw.slave)
  );

  counter_multi #(
    .WIDTH(W), .CHANNELS(C), .SATURATE(1), .PRESCALE_W(8)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave)
  );

  function automatic logic [W-1:0] ch(input logic [C*W-1:0] v,
                                      input int c);
    return v[c*W +: W];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bw.clr = 0; bw.en = '0; bw.dir = '0; bw.load = '0; bw.load_val = '0;
    bs.clr = 0; bs.en = '0; bs.dir = '0; bs.load = '0; bs.load_val = '0;
`ifdef COUNTER_PRESCALE_EN
    bw.prescale = '0;
    bs.prescale = '0;
`endif
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    idle();
    rst_n = 0;
    bw.en = '1; bw.dir = '1;
    bs.en = '1; bs.dir = '1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      tests++;
      if (bw.count !== '0 || bw.wrap !== '0 || bw.ping !== '0) begin
        fails++;
        $display("FAIL reset_w: count=%h wrap=%b ping=%b want 0", bw.count, bw.wrap, bw.ping);
      end
      tests++;
      if (bs.count !== '0 || bs.wrap !== '0 || bs.ping !== '0) begin
        fails++;
        $display("FAIL reset_s: count=%h wrap=%b ping=%b want 0", bs.count, bs.wrap, bs.ping);
      end
    end
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      exp = W'(i);
      tests++;
      if (ch(bw.count, 0) !== exp) begin
        fails++;
        $display("FAIL reset_release_%0d: ch0=%h want %h", i, ch(bw.count, 0), exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_c[3] = '{4'hF, 4'h0, 4'h1};
    logic         exp_p[3] = '{1'b1, 1'b0, 1'b0};
    logic         exp_w[3] = '{1'b0, 1'b1, 1'b0};
    idle();
    bw.load[1] = 1; bw.load_val[1*W +: W] = 4'hE;
    cyc();
    tests++;
    if (ch(bw.count, 1) !== 4'hE) begin
      fails++;
      $display("FAIL wrap_load: ch1=%h want e", ch(bw.count, 1));
    end
    bw.load = '0; bw.en[1] = 1; bw.dir[1] = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++;
      if (ch(bw.count, 1) !== exp_c[i] || bw.ping[1] !== exp_p[i] ||
          bw.wrap[1] !== exp_w[i]) begin
        fails++;
        $display("FAIL wrap_step%0d: ch1=%h ping=%b wrap=%b want %h %b %b",
                 i, ch(bw.count, 1), bw.ping[1], bw.wrap[1],
                 exp_c[i], exp_p[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_saturate();
    idle();
    bs.load[2] = 1; bs.load_val[2*W +: W] = 4'h0;
    cyc();
    bs.load = '0; bs.en[2] = 1; bs.dir[2] = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++;
      if (ch(bs.count, 2) !== 4'h0 || bs.wrap[2] !== 1'b1) begin
        fails++;
        $display("FAIL sat_down%0d: ch2=%h wrap=%b want 0 1", i, ch(bs.count, 2), bs.wrap[2]);
      end
    end
    bs.dir[2] = 1;
    for (int i = 1; i <= 2; i++) begin
      cyc();
      tests++;
      if (ch(bs.count, 2) !== W'(i) || bs.wrap[2] !== 1'b0) begin
        fails++;
        $display("FAIL sat_up%0d: ch2=%h wrap=%b want %0d 0", i, ch(bs.count, 2), bs.wrap[2], i);
      end
    end
    bs.en = '0; bs.load[2] = 1; bs.load_val[2*W +: W] = 4'hF;
    cyc();
    bs.load = '0; bs.en[2] = 1;
    cyc();
    tests++;
    if (ch(bs.count, 2) !== 4'hF || bs.wrap[2] !== 1'b1 || bs.ping[2] !== 1'b1) begin
      fails++;
      $display("FAIL sat_top: ch2=%h wrap=%b ping=%b want f 1 1",
               ch(bs.count, 2), bs.wrap[2], bs.ping[2]);
    end
    bs.en = '0;
    cyc();
    tests++;
    if (bs.wrap[2] !== 1'b0) begin
      fails++;
      $display("FAIL sat_wrap_clear: wrap=%b want 0", bs.wrap[2]);
    end
  endtask

  task automatic test_priority();
    idle();
    bw.load[3] = 1; bw.load_val[3*W +: W] = 4'h7;
    cyc();
    bw.load = '0;
    bw.clr = 1; bw.load[0] = 1; bw.load_val[0 +: W] = 4'h5; bw.en[0] = 1; bw.dir[0] = 1;
    cyc();
    tests++;
    if (bw.count !== '0) begin
      fails++;
      $display("FAIL prio_clr: count=%h want 0", bw.count);
    end
    bw.clr = 0;
    cyc();
    tests++;
    if (ch(bw.count, 0) !== 4'h5) begin
      fails++;
      $display("FAIL prio_load: ch0=%h want 5", ch(bw.count, 0));
    end
    bw.load = '0;
    cyc();
    tests++;
    if (ch(bw.count, 0) !== 4'h6) begin
      fails++;
      $display("FAIL prio_step: ch0=%h want 6", ch(bw.count, 0));
    end
  endtask

  task automatic test_independence();
    logic [W-1:0] exp1[4] = '{4'h2, 4'h1, 4'h0, 4'hF};
    logic         expw[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    idle();
    bw.load = 4'b1111;
    bw.load_val = {4'h7, 4'h0, 4'h3, 4'h0};
    cyc();
    bw.load = '0;
    bw.en = 4'b0011; bw.dir = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        bw.load[2] = 1; bw.load_val[2*W +: W] = 4'h9;
      end else begin
        bw.load = '0;
      end
      cyc();
      tests++;
      if (ch(bw.count, 0) !== W'(i + 1) || ch(bw.count, 1) !== exp1[i] ||
          bw.wrap[1] !== expw[i] || ch(bw.count, 3) !== 4'h7) begin
        fails++;
        $display("FAIL indep%0d: ch0=%h ch1=%h wrap1=%b ch3=%h want %h %h %b 7",
                 i, ch(bw.count, 0), ch(bw.count, 1), bw.wrap[1],
                 ch(bw.count, 3), W'(i + 1), exp1[i], expw[i]);
      end
    end
    tests++;
    if (ch(bw.count, 2) !== 4'h9 || bw.wrap[0] !== 1'b0) begin
      fails++;
      $display("FAIL indep_load: ch2=%h wrap0=%b want 9 0", ch(bw.count, 2), bw.wrap[0]);
    end
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale();
    logic [W-1:0] exp;
    idle();
    rst_n = 0;
    bw.prescale = 8'd2; bw.en[0] = 1; bw.dir[0] = 1;
    cyc();
    rst_n = 1;
    exp = '0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i % 3 == 0) exp = exp + 1'b1;
      tests++;
      if (ch(bw.count, 0) !== exp) begin
        fails++;
        $display("FAIL presc_cyc%0d: ch0=%h want %h", i, ch(bw.count, 0), exp);
      end
    end
    bw.prescale = 8'd0;
    for (int i = 1; i <= 2; i++) begin
      cyc();
      exp = exp + 1'b1;
      tests++;
      if (ch(bw.count, 0) !== exp) begin
        fails++;
        $display("FAIL presc_fast%0d: ch0=%h want %h", i, ch(bw.count, 0), exp);
      end
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 0;
    idle();
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_independence();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
